// File: rtl/os_framer_pp.sv
// Overlap framer: emits blocks of 2N samples (previous N plus new N) from a 3-bank ring.
// Optional block counter port blk_cnt enabled by macro OS_FRAMER_BLKCNT_EN.
module os_framer_pp #(
    parameter int DWIDTH = 9,
    parameter int OS_N   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_I,
    input  logic signed [DWIDTH-1:0] in_Q,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_start,
    output logic                     out_last,
    output logic signed [DWIDTH-1:0] out_I,
    output logic signed [DWIDTH-1:0] out_Q
`ifdef OS_FRAMER_BLKCNT_EN
    ,
    output logic [15:0]              blk_cnt
`endif
);
    localparam int LN = $clog2(OS_N);

    typedef enum logic [1:0] {WAIT, OVL, NEW} state_t;

    logic signed [DWIDTH-1:0] mem_i [3][OS_N];
    logic signed [DWIDTH-1:0] mem_q [3][OS_N];

    state_t                   st_q;
    logic [LN-1:0]            fidx_q;
    logic [1:0]               fbank_q, obank_q, nbank_q;
    logic [LN:0]              oidx_q;
    logic                     pend_q, first_q, bfirst_q, in_ready_q;
    logic                     ov_q, os_q, ol_q;
    logic signed [DWIDTH-1:0] oi_q, oq_q;

    logic        acc, bank_done, hs, blk_end, start, ld, zero, pend_d;
    logic [LN:0] ld_idx;
    logic [1:0]  ld_bank, rd_bank;

    assign acc       = in_valid && in_ready_q;
    assign bank_done = acc && (fidx_q == LN'(OS_N - 1));
    assign hs        = ov_q && out_ready;
    assign blk_end   = hs && ol_q;
    // A block may start as soon as its new bank is complete, even in the same cycle
    assign start     = (pend_q || bank_done) && (st_q == WAIT || blk_end);
    assign ld        = start || (hs && !ol_q);
    assign ld_idx    = start ? '0 : oidx_q + (LN+1)'(1);
    assign ld_bank   = start ? nbank_q : obank_q;
    assign rd_bank   = ld_idx[LN] ? ld_bank : ((ld_bank == 2'd0) ? 2'd2 : ld_bank - 2'd1);
    assign zero      = !ld_idx[LN] && (start ? first_q : bfirst_q);
    // Holding a second complete bank while a block is active means the next fill would hit the overlap bank
    assign pend_d    = (pend_q || bank_done) && !start;

    always_ff @(posedge clk) begin
        if (acc) begin
            mem_i[fbank_q][fidx_q] <= in_I;
            mem_q[fbank_q][fidx_q] <= in_Q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= WAIT;
            fidx_q     <= '0;
            fbank_q    <= 2'd0;
            obank_q    <= 2'd0;
            nbank_q    <= 2'd0;
            oidx_q     <= '0;
            pend_q     <= 1'b0;
            first_q    <= 1'b1;
            bfirst_q   <= 1'b1;
            in_ready_q <= 1'b1;
            ov_q       <= 1'b0;
            os_q       <= 1'b0;
            ol_q       <= 1'b0;
            oi_q       <= '0;
            oq_q       <= '0;
        end else begin
            if (acc) begin
                fidx_q <= fidx_q + LN'(1);
                if (bank_done) fbank_q <= (fbank_q == 2'd2) ? 2'd0 : fbank_q + 2'd1;
            end
            pend_q     <= pend_d;
            in_ready_q <= !pend_d;
            if (start) begin
                obank_q  <= nbank_q;
                nbank_q  <= (nbank_q == 2'd2) ? 2'd0 : nbank_q + 2'd1;
                bfirst_q <= first_q;
                first_q  <= 1'b0;
            end
            if (ld) begin
                st_q   <= ld_idx[LN] ? NEW : OVL;
                oidx_q <= ld_idx;
                ov_q   <= 1'b1;
                os_q   <= (ld_idx == '0);
                ol_q   <= (ld_idx == (LN+1)'(2*OS_N - 1));
                oi_q   <= zero ? '0 : mem_i[rd_bank][ld_idx[LN-1:0]];
                oq_q   <= zero ? '0 : mem_q[rd_bank][ld_idx[LN-1:0]];
            end else if (blk_end) begin
                st_q <= WAIT;
                ov_q <= 1'b0;
                os_q <= 1'b0;
                ol_q <= 1'b0;
            end
        end
    end

`ifdef OS_FRAMER_BLKCNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_q <= '0;
        else if (blk_end) cnt_q <= cnt_q + 16'd1;
    end
    assign blk_cnt = cnt_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = ov_q;
    assign out_start = os_q;
    assign out_last  = ol_q;
    assign out_I     = oi_q;
    assign out_Q     = oq_q;
endmodule

// File: tb/tb_os_framer_pp.sv
// Scoreboard bench for os_framer_pp: ramp input, expected blocks queued, monitor pops on handshake.
module tb_os_framer_pp;
    localparam int DW = 9;
    localparam int N  = 16;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_start, out_last;
    logic signed [DW-1:0] in_I = DW'(1), in_Q = ~DW'(1), out_I, out_Q;
`ifdef OS_FRAMER_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    os_framer_pp #(.DWIDTH(DW), .OS_N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_I(in_I), .in_Q(in_Q), .out_ready(out_ready), .out_valid(out_valid),
        .out_start(out_start), .out_last(out_last), .out_I(out_I), .out_Q(out_Q)
`ifdef OS_FRAMER_BLKCNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          s;
        logic          l;
    } exp_t;

    exp_t expq[$];
    int checks = 0, failures = 0, popped = 0, n = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Sample v of the ramp is I=v, Q=~v; v==0 denotes a forced-zero overlap sample
    task automatic push_block(int k, int cnt);
        exp_t e;
        int v;
        for (int j = 0; j < cnt; j++) begin
            if (j < N) v = (k == 0) ? 0 : (k-1)*N + j + 1;
            else       v = k*N + (j - N) + 1;
            e.i = DW'(v);
            e.q = (v == 0) ? '0 : ~DW'(v);
            e.s = (j == 0);
            e.l = (j == 2*N-1);
            expq.push_back(e);
        end
    endtask

    task automatic wait_pop(int target);
        int b = 0;
        while (popped < target && b < 3000) begin
            @(posedge clk);
            b++;
        end
        #1;
        if (popped < target) begin
            failures++;
            $display("FAIL timeout popped=%0d required=%0d", popped, target);
        end
    endtask

    // Input driver: ramp value advances on each accepted sample, restarts at 1 after reset
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready && !rst;
            @(posedge clk);
            if (rst)      n = 0;
            else if (acc) n++;
            #1;
            in_I = DW'(n + 1);
            in_Q = ~DW'(n + 1);
        end
    end

    // Monitor: pops on handshake, checks hold stability and back-to-back blocks
    exp_t held;
    bit held_v = 0, last_hs = 0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = {out_I, out_Q, out_start, out_last};
        if (rst) begin
            held_v  = 0;
            last_hs = 0;
        end else begin
            if (last_hs) chk("gap", {30'd0, out_valid, out_start}, 32'd3);
            last_hs = 0;
            if (held_v) chk("hold", 32'(cur), 32'(held));
            held_v = 0;
            if (out_valid && !out_ready) begin
                held   = cur;
                held_v = 1;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none", cur);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("sample%0d", popped), 32'(cur), 32'(e));
                end
                popped++;
                last_hs = out_last;
            end
        end
    end

    initial begin
        int lat_n;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_block(k, 2*N);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_start", 32'(out_start), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_I",     32'(out_I),     32'd0);
        chk("rst_Q",     32'(out_Q),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        lat_n = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat_n = n;
                break;
            end
        end
        chk("latency_accepted", 32'(lat_n), 32'd16);

        wait_pop(160);
        out_ready = 1'b0;
`ifdef OS_FRAMER_BLKCNT_EN
        chk("blk_cnt", 32'(blk_cnt), 32'd5);
`endif

        // Downstream stall: input must stop once the bank after the active block fills
        repeat (40) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_accepted", 32'(n), 32'd112);
        push_block(5, 2*N);
        push_block(6, 2*N);
        out_ready = 1'b1;
        wait_pop(224);
        out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) push_block(k, 2*N);
        push_block(3, 20);
        out_ready = 1'b1;
        wait_pop(340);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_start", 32'(out_start), 32'd0);
        chk("midrst_queue", 32'(expq.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push_block(0, 2*N);
        push_block(1, 2*N);
        wait_pop(404);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
